// File: rtl/address_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : address_unit_pkg
//  Description : Address-select codes shared by the decoder and address unit.
//  Revision    : 1.0  initial release
// ============================================================================
package address_unit_pkg;

    localparam logic [1:0] ADR_SEL_PC  = 2'd0;
    localparam logic [1:0] ADR_SEL_MEM = 2'd1;
    localparam logic [1:0] ADR_SEL_ALU = 2'd2;
    localparam logic [1:0] ADR_SEL_RSV = 2'd3;

endpackage
`default_nettype wire

// File: rtl/address_unit_program_counter.sv
`default_nettype none
// ============================================================================
//  Module      : program_counter
//  Description : 16-bit PC with synchronous clear, byte-wise load, increment.
//  Revision    : 1.0  initial release
// ============================================================================
module program_counter (
    input  logic        clk,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic        load_lo,
    input  logic        load_hi,
    input  logic [7:0]  load_data,
    input  logic        i_increment,
    output logic [15:0] o_pc
);

    logic [15:0] r_pc;

    // Clear wins even when the unit is stalled.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_pc <= 16'h0000;
        end else if (i_enable) begin
            if (load_lo) begin
                r_pc[7:0] <= load_data;
            end else if (load_hi) begin
                r_pc[15:8] <= load_data;
            end else if (i_increment) begin
                r_pc <= r_pc + 16'd1;
            end
        end
    end

    assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/address_unit.sv
`default_nettype none
// ============================================================================
//  Module      : address_unit
//  Description : 6502 address-bus unit: PC ownership, reset-vector fetch and
//                external address / rw multiplexing.
//  Revision    : 1.0  initial release
// ============================================================================
module address_unit
    import address_unit_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
    input  logic        clk,
    input  logic        res,
    input  logic        rdy,
    input  logic        pc_enable,
    input  logic [1:0]  address_select,
    input  logic [15:0] memory_address,
    input  logic [7:0]  alu_result,
    input  logic        rw_in,
    input  logic [7:0]  data_in,
    output logic [15:0] address_out,
    output logic        rw_out,
    output logic [15:0] pc_out,
    output logic        decode_hold
);

    localparam logic [1:0] S_VEC_LO = 2'd0;
    localparam logic [1:0] S_VEC_HI = 2'd1;
    localparam logic [1:0] S_VEC_LD = 2'd2;
    localparam logic [1:0] S_RUN    = 2'd3;

    localparam logic [15:0] c_VEC_HI_ADDR = RESET_VECTOR + 16'd1;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        w_load_lo;
    logic        w_load_hi;
    logic        w_increment;
    logic [15:0] w_pc;

    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= S_VEC_LO;
        end else if (rdy) begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_VEC_LO: w_next_state = S_VEC_HI;
            S_VEC_HI: w_next_state = S_VEC_LD;
            S_VEC_LD: w_next_state = S_RUN;
            default:  w_next_state = S_RUN;
        endcase
    end

    // Each vector byte is captured one state after its address was driven,
    // matching the one-cycle read latency of the external bus.
    always_comb begin
        address_out = RESET_VECTOR;
        rw_out      = 1'b1;
        decode_hold = 1'b1;
        w_load_lo   = 1'b0;
        w_load_hi   = 1'b0;
        w_increment = 1'b0;
        case (r_state)
            S_VEC_LO: begin
                address_out = RESET_VECTOR;
            end
            S_VEC_HI: begin
                address_out = c_VEC_HI_ADDR;
                w_load_lo   = 1'b1;
            end
            S_VEC_LD: begin
                address_out = c_VEC_HI_ADDR;
                w_load_hi   = 1'b1;
            end
            default: begin
                decode_hold = 1'b0;
                rw_out      = rw_in;
                w_increment = pc_enable;
                case (address_select)
                    ADR_SEL_MEM: address_out = memory_address;
                    ADR_SEL_ALU: address_out = {8'h00, alu_result};
                    default:     address_out = w_pc;
                endcase
            end
        endcase
    end

    program_counter u_program_counter (
        .clk         (clk),
        .i_clear     (res),
        .i_enable    (rdy),
        .load_lo     (w_load_lo),
        .load_hi     (w_load_hi),
        .load_data   (data_in),
        .i_increment (w_increment),
        .o_pc        (w_pc)
    );

    assign pc_out = w_pc;

endmodule
`default_nettype wire
